axil_cmd_master: RTL and testbench



---
 rtl/axil_cmd_pkg.sv | 18 +
 rtl/axil_cmd_master_if.sv | 40 ++++
 rtl/axil_cmd_master.sv | 187 ++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_cmd_pkg.sv
// Shared types and AXI response codes for the AXI4-Lite command master.
// Imported by the master and its testbench.
package axil_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } axil_cmd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bundle with all five channels.
// The master modport drives requests; the slave modport drives responses.
interface axil_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axil_cmd_master.sv
// Turns a command/response stream into single AXI4-Lite transactions,
// one outstanding at a time, with a watchdog that aborts hung slaves.
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                axilite_clk,
  input  logic                axilite_rst,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,

  axil_cmd_master_if.master   m_axil
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  axil_cmd_state_t      state_q;
  logic                 cmdReady_q;
  logic                 awValid_q;
  logic                 wValid_q;
  logic                 bReady_q;
  logic                 arValid_q;
  logic                 rReady_q;
  logic                 rspValid_q;
  logic [DATA_W-1:0]    rspRdata_q;
  logic [1:0]           rspResp_q;
  logic                 rspTimeout_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W/8-1:0]  wstrb_q;
  logic [CNT_W-1:0]     wdog_q;
  logic [CNT_W-1:0]     wdog_d;

  logic awDone;
  logic wDone;
  logic busy;
  logic stepDone;
  logic expired;

  // A channel counts as done once its valid has dropped or it handshakes now.
  always_comb begin
    awDone   = !awValid_q || m_axil.awready;
    wDone    = !wValid_q  || m_axil.wready;
    busy     = 1'b0;
    stepDone = 1'b0;
    case (state_q)
      WR:    begin busy = 1'b1; stepDone = awDone && wDone;   end
      WR_B:  begin busy = 1'b1; stepDone = m_axil.bvalid;     end
      RD_AR: begin busy = 1'b1; stepDone = m_axil.arready;    end
      RD_R:  begin busy = 1'b1; stepDone = m_axil.rvalid;     end
      default: ;
    endcase
    expired = (wdog_q == CNT_MAX);
    wdog_d  = expired ? wdog_q : wdog_q + 1'b1;
  end

  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      state_q      <= IDLE;
      cmdReady_q   <= 1'b0;
      awValid_q    <= 1'b0;
      wValid_q     <= 1'b0;
      bReady_q     <= 1'b0;
      arValid_q    <= 1'b0;
      rReady_q     <= 1'b0;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
      rspResp_q    <= RESP_OKAY;
      rspTimeout_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wdog_q       <= '0;
    end else if (busy && expired && !stepDone) begin
      // Completing handshakes win over expiry; otherwise abandon the bus.
      awValid_q    <= 1'b0;
      wValid_q     <= 1'b0;
      bReady_q     <= 1'b0;
      arValid_q    <= 1'b0;
      rReady_q     <= 1'b0;
      rspValid_q   <= 1'b1;
      rspRdata_q   <= '0;
      rspResp_q    <= RESP_SLVERR;
      rspTimeout_q <= 1'b1;
      state_q      <= RSP;
    end else begin
      if (busy) wdog_q <= wdog_d;
      case (state_q)
        IDLE: begin
          cmdReady_q <= 1'b1;
          if (cmdReady_q && cmd_valid) begin
            cmdReady_q <= 1'b0;
            addr_q     <= cmd_addr;
            wdata_q    <= cmd_wdata;
            wstrb_q    <= cmd_wstrb;
            wdog_q     <= '0;
            if (cmd_wr) begin
              awValid_q <= 1'b1;
              wValid_q  <= 1'b1;
              state_q   <= WR;
            end else begin
              arValid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        WR: begin
          if (m_axil.awready) awValid_q <= 1'b0;
          if (m_axil.wready)  wValid_q  <= 1'b0;
          if (awDone && wDone) begin
            bReady_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (m_axil.bvalid) begin
            bReady_q     <= 1'b0;
            rspValid_q   <= 1'b1;
            rspRdata_q   <= '0;
            rspResp_q    <= m_axil.bresp;
            rspTimeout_q <= 1'b0;
            state_q      <= RSP;
          end
        end
        RD_AR: begin
          if (m_axil.arready) begin
            arValid_q <= 1'b0;
            rReady_q  <= 1'b1;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (m_axil.rvalid) begin
            rReady_q     <= 1'b0;
            rspValid_q   <= 1'b1;
            rspRdata_q   <= m_axil.rdata;
            rspResp_q    <= m_axil.rresp;
            rspTimeout_q <= 1'b0;
            state_q      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            cmdReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = cmdReady_q;
  assign rsp_valid      = rspValid_q;
  assign rsp_rdata      = rspRdata_q;
  assign rsp_resp       = rspResp_q;
  assign rsp_timeout    = rspTimeout_q;

  assign m_axil.awvalid = awValid_q;
  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.wvalid  = wValid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.bready  = bReady_q;
  assign m_axil.arvalid = arValid_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.rready  = rReady_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a small behavioural AXI-Lite
// slave covering rf_ctrl, regs and unmapped space, with stall/hang knobs.
module tb_axil_cmd_master;
  import axil_cmd_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int TB_TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axil_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axil ();

  axil_cmd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .axilite_clk(clk),       .axilite_rst(rst),
    .cmd_valid(cmd_valid),   .cmd_ready(cmd_ready),   .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr),     .cmd_wdata(cmd_wdata),   .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),   .rsp_ready(rsp_ready),   .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),     .rsp_timeout(rsp_timeout),
    .m_axil(axil)
  );

  // Slave model: stall knobs hold ready low for N cycles of valid; bHold withholds B.
  int          awStallReq = 0;
  int          wStallReq  = 0;
  bit          arEnable   = 1'b1;
  bit          bHold      = 1'b0;
  int          awStallCnt;
  int          wStallCnt;
  int          awHsCount  = 0;
  int          wHsCount   = 0;
  logic        awGot;
  logic        wGot;
  logic [31:0] slvAddr;
  logic [31:0] slvData;
  logic [3:0]  slvStrb;
  bit   [31:0] mem [bit [31:0]];

  function automatic logic [1:0] decodeResp(input logic [31:0] a);
    return (a < 32'h0011_0000) ? RESP_OKAY : RESP_DECERR;
  endfunction

  assign axil.awready = !awGot && (awStallCnt >= awStallReq);
  assign axil.wready  = !wGot  && (wStallCnt  >= wStallReq);
  assign axil.arready = arEnable && !axil.rvalid;

  always @(posedge clk) begin : slaveModel
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] word;
    if (rst) begin
      awGot       <= 1'b0;
      wGot        <= 1'b0;
      awStallCnt  <= 0;
      wStallCnt   <= 0;
      axil.bvalid <= 1'b0;
      axil.bresp  <= 2'b00;
      axil.rvalid <= 1'b0;
      axil.rdata  <= '0;
      axil.rresp  <= 2'b00;
    end else begin
      if (axil.awvalid && !axil.awready && !awGot) awStallCnt <= awStallCnt + 1;
      if (axil.wvalid && !axil.wready && !wGot) wStallCnt <= wStallCnt + 1;
      if (axil.awvalid && axil.awready) begin
        awGot      <= 1'b1;
        slvAddr    <= axil.awaddr;
        awHsCount  <= awHsCount + 1;
        awStallCnt <= 0;
      end
      if (axil.wvalid && axil.wready) begin
        wGot      <= 1'b1;
        slvData   <= axil.wdata;
        slvStrb   <= axil.wstrb;
        wHsCount  <= wHsCount + 1;
        wStallCnt <= 0;
      end
      if ((awGot || (axil.awvalid && axil.awready)) &&
          (wGot  || (axil.wvalid  && axil.wready)) && !axil.bvalid && !bHold) begin
        wa = awGot ? slvAddr : axil.awaddr;
        wd = wGot  ? slvData : axil.wdata;
        ws = wGot  ? slvStrb : axil.wstrb;
        if (decodeResp(wa) == RESP_OKAY) begin
          word = mem.exists(wa) ? mem[wa] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (ws[b]) word[8*b +: 8] = wd[8*b +: 8];
          mem[wa] = word;
        end
        axil.bvalid <= 1'b1;
        axil.bresp  <= decodeResp(wa);
      end
      if (axil.bvalid && axil.bready) begin
        axil.bvalid <= 1'b0;
        awGot       <= 1'b0;
        wGot        <= 1'b0;
      end
      if (axil.arvalid && axil.arready) begin
        axil.rvalid <= 1'b1;
        axil.rresp  <= decodeResp(axil.araddr);
        axil.rdata  <= (decodeResp(axil.araddr) == RESP_OKAY && mem.exists(axil.araddr))
                       ? mem[axil.araddr] : 32'h0;
      end
      if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Returns at the falling edge of cycle 1 (cycle 0 being the accept cycle).
  task automatic issueCmd(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    int waitCnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    waitCnt   = 0;
    while (!cmd_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_accept_wait", 64'(cmd_ready), 64'h1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic collectRsp(input int startLat, output logic [31:0] rdata,
                            output logic [1:0] resp, output logic tmo, output int lat);
    lat = startLat;
    while (!rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) checkOutput("rsp_wait", 64'(rsp_valid), 64'h1);
    rdata = rsp_rdata;
    resp  = rsp_resp;
    tmo   = rsp_timeout;
  endtask

  task automatic consumeRsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", 64'(rsp_valid), 64'h0);
    checkOutput("cmd_ready_after_rsp", 64'(cmd_ready), 64'h1);
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               output logic [31:0] rdata, output logic [1:0] resp,
                               output logic tmo, output int lat);
    issueCmd(wr, addr, data, strb);
    collectRsp(1, rdata, resp, tmo, lat);
    consumeRsp();
  endtask

  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        tmo;
  int          lat;
  int          awBefore;
  int          wBefore;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'h0);
    checkOutput("rst_valids",
                64'({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready,
                     rsp_valid, rsp_timeout}), 64'h0);
    checkOutput("rst_rsp_data", 64'({rsp_resp, rsp_rdata}), 64'h0);
    checkOutput("prot_tied", 64'({axil.awprot, axil.arprot}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("cmd_ready_after_rst", 64'(cmd_ready), 64'h1);

    // rf_ctrl write with per-cycle latency checks
    issueCmd(1'b1, 32'h0000_0000, 32'h10, 4'hF);
    checkOutput("wr_aw_w_valid", 64'({axil.awvalid, axil.wvalid}), 64'h3);
    checkOutput("wr_awaddr", 64'(axil.awaddr), 64'h0);
    checkOutput("wr_wdata", 64'(axil.wdata), 64'h10);
    collectRsp(1, rdata, resp, tmo, lat);
    checkOutput("wr_latency", 64'(lat), 64'd3);
    checkOutput("wr_resp", 64'({tmo, resp, rdata}), 64'h0);
    consumeRsp();

    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 4'h0, rdata, resp, tmo, lat);
    checkOutput("rd_latency", 64'(lat), 64'd3);
    checkOutput("rd_rf_ctrl", 64'({tmo, resp, rdata}), 64'h10);

    // regs region, then confirm rf_ctrl is untouched
    applyStimulus(1'b1, 32'h0010_0000, 32'h40, 4'hF, rdata, resp, tmo, lat);
    checkOutput("wr_regs_resp", 64'({tmo, resp}), 64'h0);
    applyStimulus(1'b0, 32'h0010_0000, 32'h0, 4'h0, rdata, resp, tmo, lat);
    checkOutput("rd_regs", 64'({tmo, resp, rdata}), 64'h40);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 4'h0, rdata, resp, tmo, lat);
    checkOutput("rd_rf_ctrl_again", 64'(rdata), 64'h10);

    // unmapped address: DECERR forwarded promptly, no timeout
    applyStimulus(1'b1, 32'h0100_0000, 32'h50, 4'hF, rdata, resp, tmo, lat);
    checkOutput("unmapped_resp", 64'({tmo, resp}), 64'h3);
    checkOutput("unmapped_latency", 64'(lat), 64'd3);

    // awready stalled 20 cycles, wready 5: AW lands cycle 21, B cycle 22, rsp cycle 23
    awStallReq = 20;
    wStallReq  = 5;
    awBefore   = awHsCount;
    wBefore    = wHsCount;
    issueCmd(1'b1, 32'h0010_0008, 32'hA5A5_A5A5, 4'hF);
    repeat (9) @(negedge clk);
    checkOutput("stall_w_dropped_aw_held", 64'({axil.awvalid, axil.wvalid}), 64'h2);
    collectRsp(10, rdata, resp, tmo, lat);
    checkOutput("stall_latency", 64'(lat), 64'd23);
    checkOutput("stall_resp", 64'({tmo, resp}), 64'h0);
    consumeRsp();
    checkOutput("stall_aw_count", 64'(awHsCount - awBefore), 64'd1);
    checkOutput("stall_w_count", 64'(wHsCount - wBefore), 64'd1);
    awStallReq = 0;
    wStallReq  = 0;

    // partial strobe merges the low half-word only
    applyStimulus(1'b1, 32'h0010_0008, 32'hFFFF_1234, 4'b0011, rdata, resp, tmo, lat);
    applyStimulus(1'b0, 32'h0010_0008, 32'h0, 4'h0, rdata, resp, tmo, lat);
    checkOutput("strobe_merge", 64'(rdata), 64'hA5A5_1234);

    // hung slave: arvalid held for TB_TIMEOUT cycles, SLVERR+timeout after that
    arEnable = 1'b0;
    issueCmd(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    checkOutput("tmo_ar_still_valid", 64'({axil.arvalid, rsp_valid}), 64'h2);
    collectRsp(TB_TIMEOUT, rdata, resp, tmo, lat);
    checkOutput("tmo_latency", 64'(lat), 64'(TB_TIMEOUT + 1));
    checkOutput("tmo_rsp", 64'({tmo, resp, rdata}), 64'h2_0000_0000 | 64'h4_0000_0000);
    checkOutput("tmo_bus_idle", 64'({axil.arvalid, axil.rready}), 64'h0);
    consumeRsp();
    arEnable = 1'b1;
    applyStimulus(1'b0, 32'h0010_0000, 32'h0, 4'h0, rdata, resp, tmo, lat);
    checkOutput("after_tmo_read", 64'({tmo, resp, rdata}), 64'h40);

    // response held stable across 10 cycles of backpressure
    issueCmd(1'b1, 32'h0010_0004, 32'h77, 4'hF);
    collectRsp(1, rdata, resp, tmo, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("backpressure_%0d", i),
                  64'({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}), 64'h8_0000_0000);
    end
    consumeRsp();
    applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'h0, rdata, resp, tmo, lat);
    checkOutput("backpressure_readback", 64'(rdata), 64'h77);

    // reset while waiting in WR_B
    bHold = 1'b1;
    issueCmd(1'b1, 32'h0000_0004, 32'h99, 4'hF);
    repeat (2) @(negedge clk);
    checkOutput("in_wr_b", 64'({axil.bready, axil.awvalid, axil.wvalid}), 64'h4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cmd_ready", 64'(cmd_ready), 64'h0);
    checkOutput("midrst_valids",
                64'({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready,
                     rsp_valid, rsp_timeout}), 64'h0);
    checkOutput("midrst_rsp_data", 64'({rsp_resp, rsp_rdata}), 64'h0);
    rst   = 1'b0;
    bHold = 1'b0;
    @(negedge clk);
    checkOutput("midrst_cmd_ready_after", 64'(cmd_ready), 64'h1);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 4'h0, rdata, resp, tmo, lat);
    checkOutput("after_midrst_read", 64'({tmo, resp, rdata}), 64'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, got hang expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
